// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the regfile_mp register file and its scoreboard.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREGS  = 16;
  localparam int DEF_NRD    = 4;
  localparam int DEF_NWR    = 2;

  function automatic int calcAw(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

  function automatic int defPcReg(input int nregs);
    return nregs - 1;
  endfunction

  function automatic int sliceLsb(input int port, input int width);
    return port * width;
  endfunction

  // The PC slot has no storage, so rows above it shift down by one.
  function automatic int storeRow(input int addr, input int pcReg);
    return (addr > pcReg) ? addr - 1 : addr;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Port bundle between the decode stage (master) and regfile_mp (slave).
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = DEF_NREGS,
  parameter int NRD    = DEF_NRD,
  parameter int NWR    = DEF_NWR
);

  localparam int AW = calcAw(NREGS);

  logic [NWR-1:0]        we;
  logic [NWR*AW-1:0]     wa;
  logic [NWR*DATA_W-1:0] wd;
  logic [NRD*AW-1:0]     ra;
  logic [DATA_W-1:0]     pc_in;
  logic                  sb_set;
  logic [AW-1:0]         sb_addr;
  logic [NRD-1:0]        rd_use;
  logic [NRD*DATA_W-1:0] rd;
  logic [NRD-1:0]        rd_busy;
  logic                  stall;

  modport master (
    output we, wa, wd, ra, pc_in, sb_set, sb_addr, rd_use,
    input  rd, rd_busy, stall
  );

  modport slave (
    input  we, wa, wd, ra, pc_in, sb_set, sb_addr, rd_use,
    output rd, rd_busy, stall
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-bit array for multi-cycle producers; a set beats a clearing write to the same register.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS  = DEF_NREGS,
  parameter int NRD    = DEF_NRD,
  parameter int NWR    = DEF_NWR,
  parameter int PC_REG = NREGS - 1,
  parameter int AW     = calcAw(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NWR-1:0]    we_i,
  input  logic [NWR*AW-1:0] wa_i,
  input  logic              sbSet_i,
  input  logic [AW-1:0]     sbAddr_i,
  input  logic [NRD*AW-1:0] ra_i,
  output logic [NRD-1:0]    busy_o
);

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NWR; i++) begin
      if (we_i[i] && (int'(wa_i[i*AW +: AW]) < NREGS))
        pending_d[wa_i[i*AW +: AW]] = 1'b0;
    end
    if (sbSet_i && (int'(sbAddr_i) < NREGS) && (int'(sbAddr_i) != PC_REG))
      pending_d[sbAddr_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  always_comb begin
    busy_o = '0;
    for (int j = 0; j < NRD; j++) begin
      if ((int'(ra_i[j*AW +: AW]) < NREGS) && (int'(ra_i[j*AW +: AW]) != PC_REG))
        busy_o[j] = pending_q[ra_i[j*AW +: AW]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with port-0-priority writes, external PC slot and pending scoreboard.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = DEF_NREGS,
  parameter int NRD    = DEF_NRD,
  parameter int NWR    = DEF_NWR,
  parameter int PC_REG = NREGS - 1
) (
  input logic         clk,
  input logic         reset,
  regfile_mp_if.slave bus
);

  localparam int AW     = calcAw(NREGS);
  localparam int NSTORE = NREGS - 1;

  logic [DATA_W-1:0]     regs_q [NSTORE];
  logic [DATA_W-1:0]     regs_d [NSTORE];
  logic [NRD-1:0]        sbBusy;
  logic [NRD-1:0]        rdBusy;
  logic [NRD*DATA_W-1:0] rdData;

  function automatic logic isStored(input logic [AW-1:0] a);
    return (int'(a) < NREGS) && (int'(a) != PC_REG);
  endfunction

  // Walk ports high to low so the lowest-index writer lands last and wins.
  always_comb begin
    regs_d = regs_q;
    for (int i = NWR - 1; i >= 0; i--) begin
      if (bus.we[i] && isStored(bus.wa[sliceLsb(i, AW) +: AW]))
        regs_d[storeRow(int'(bus.wa[sliceLsb(i, AW) +: AW]), PC_REG)] =
          bus.wd[sliceLsb(i, DATA_W) +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NSTORE; k++) regs_q[k] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NRD    (NRD),
    .NWR    (NWR),
    .PC_REG (PC_REG),
    .AW     (AW)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .we_i     (bus.we),
    .wa_i     (bus.wa),
    .sbSet_i  (bus.sb_set),
    .sbAddr_i (bus.sb_addr),
    .ra_i     (bus.ra),
    .busy_o   (sbBusy)
  );

  always_comb begin
    rdData = '0;
    rdBusy = sbBusy;
    for (int j = 0; j < NRD; j++) begin
      if (int'(bus.ra[sliceLsb(j, AW) +: AW]) == PC_REG)
        rdData[sliceLsb(j, DATA_W) +: DATA_W] = bus.pc_in;
      else if (isStored(bus.ra[sliceLsb(j, AW) +: AW]))
        rdData[sliceLsb(j, DATA_W) +: DATA_W] =
          regs_q[storeRow(int'(bus.ra[sliceLsb(j, AW) +: AW]), PC_REG)];
`ifdef REGFILE_BYPASS_EN
      // Forwarded data is current, so busy drops unless a new producer claims the register.
      if (reset && isStored(bus.ra[sliceLsb(j, AW) +: AW])) begin
        for (int i = NWR - 1; i >= 0; i--) begin
          if (bus.we[i] && (bus.wa[sliceLsb(i, AW) +: AW] == bus.ra[sliceLsb(j, AW) +: AW])) begin
            rdData[sliceLsb(j, DATA_W) +: DATA_W] = bus.wd[sliceLsb(i, DATA_W) +: DATA_W];
            if (!(bus.sb_set && (bus.sb_addr == bus.ra[sliceLsb(j, AW) +: AW])))
              rdBusy[j] = 1'b0;
          end
        end
      end
`endif
    end
  end

  assign bus.rd      = rdData;
  assign bus.rd_busy = rdBusy;
  assign bus.stall   = |(rdBusy & bus.rd_use);

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed steps then random traffic against an array model.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DATA_W = 32;
  localparam int NREGS  = 16;
  localparam int NRD    = 4;
  localparam int NWR    = 2;
  localparam int PC_REG = 15;
  localparam int AW     = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [DATA_W-1:0] modelMem  [NREGS];
  bit                modelPend [NREGS];

  regfile_mp_if #(.DATA_W(DATA_W), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

  regfile_mp #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .NRD    (NRD),
    .NWR    (NWR),
    .PC_REG (PC_REG)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int waOf(input int i);
    return int'(bus.wa[i*AW +: AW]);
  endfunction

  function automatic logic [DATA_W-1:0] wdOf(input int i);
    return bus.wd[i*DATA_W +: DATA_W];
  endfunction

  function automatic int raOf(input int j);
    return int'(bus.ra[j*AW +: AW]);
  endfunction

  function automatic logic [DATA_W-1:0] rdOf(input int j);
    return bus.rd[j*DATA_W +: DATA_W];
  endfunction

  // Index of the winning same-cycle writer for address a, or -1 when none.
  function automatic int winner(input int a);
    for (int i = 0; i < NWR; i++)
      if (bus.we[i] && waOf(i) == a) return i;
    return -1;
  endfunction

  function automatic logic [DATA_W-1:0] expRead(input int j);
    int a;
    a = raOf(j);
    if (a == PC_REG) return bus.pc_in;
`ifdef REGFILE_BYPASS_EN
    if (reset && winner(a) >= 0) return wdOf(winner(a));
`endif
    return modelMem[a];
  endfunction

  function automatic bit expBusy(input int j);
    int a;
    a = raOf(j);
    if (a == PC_REG) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (reset && winner(a) >= 0 && !(bus.sb_set && int'(bus.sb_addr) == a)) return 1'b0;
`endif
    return modelPend[a];
  endfunction

  task automatic modelClear();
    for (int k = 0; k < NREGS; k++) begin
      modelMem[k]  = '0;
      modelPend[k] = 1'b0;
    end
  endtask

  task automatic modelCommit();
    logic [DATA_W-1:0] nextMem [NREGS];
    if (!reset) return;
    nextMem = modelMem;
    for (int a = 0; a < NREGS; a++) begin
      if (a != PC_REG && winner(a) >= 0) nextMem[a] = wdOf(winner(a));
      if (winner(a) >= 0) modelPend[a] = 1'b0;
    end
    if (bus.sb_set && int'(bus.sb_addr) != PC_REG) modelPend[bus.sb_addr] = 1'b1;
    modelMem = nextMem;
  endtask

  task automatic applyStimulus(
    input logic [1:0]  we,
    input logic [3:0]  wa0, input logic [31:0] wd0,
    input logic [3:0]  wa1, input logic [31:0] wd1,
    input logic [3:0]  r0, input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] r3,
    input logic [3:0]  use_,
    input logic        sbSet,
    input logic [3:0]  sbAddr
  );
    bus.we      = we;
    bus.wa      = {wa1, wa0};
    bus.wd      = {wd1, wd0};
    bus.ra      = {r3, r2, r1, r0};
    bus.rd_use  = use_;
    bus.sb_set  = sbSet;
    bus.sb_addr = sbAddr;
  endtask

  task automatic idle(input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2,
                      input logic [3:0] r3, input logic [3:0] use_);
    applyStimulus(2'b00, 4'd0, 32'd0, 4'd0, 32'd0, r0, r1, r2, r3, use_, 1'b0, 4'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    modelCommit();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag);
    bit expStall;
    expStall = 1'b0;
    for (int j = 0; j < NRD; j++) begin
      checks++;
      assert (rdOf(j) === expRead(j)) else begin
        errors++;
        $error("[TB] FAIL %s rd%0d: got %h expected %h", tag, j, rdOf(j), expRead(j));
      end
      checks++;
      assert (bus.rd_busy[j] === expBusy(j)) else begin
        errors++;
        $error("[TB] FAIL %s busy%0d: got %b expected %b", tag, j, bus.rd_busy[j], expBusy(j));
      end
      expStall = expStall | (expBusy(j) & bus.rd_use[j]);
    end
    checks++;
    assert (bus.stall === expStall) else begin
      errors++;
      $error("[TB] FAIL %s stall: got %b expected %b", tag, bus.stall, expStall);
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] w0;
    modelClear();
    bus.pc_in = 32'h0000_1008;
    idle(4'd3, 4'd15, 4'd0, 4'd0, 4'hF);
    #2;
    checkOutput("reset");
    checkValue("reset rd0", rdOf(0), 32'h0);
    checkValue("reset rd1 pc", rdOf(1), 32'h0000_1008);

    // A write presented while reset is held must be discarded.
    applyStimulus(2'b11, 4'd3, 32'h3333_3333, 4'd3, 32'h4444_4444,
                  4'd3, 4'd15, 4'd0, 4'd0, 4'hF, 1'b1, 4'd3);
    tick();
    idle(4'd3, 4'd15, 4'd0, 4'd0, 4'hF);
    #1 checkOutput("reset write");
    checkValue("reset write dropped", rdOf(0), 32'h0);

    reset = 1'b1;
    #1 checkOutput("release");
    tick();
    #1 checkOutput("idle");

    $display("[TB] write port priority");
    applyStimulus(2'b11, 4'd5, 32'hAAAA_0000, 4'd5, 32'h5555_FFFF,
                  4'd5, 4'd0, 4'd0, 4'd0, 4'h0, 1'b0, 4'd0);
    #1 checkOutput("prio pre");
    tick();
    idle(4'd5, 4'd4, 4'd6, 4'd0, 4'h0);
    #1 checkOutput("prio post");
    checkValue("prio r5", rdOf(0), 32'hAAAA_0000);

    applyStimulus(2'b11, 4'd4, 32'h4444_4444, 4'd6, 32'h6666_6666,
                  4'd5, 4'd4, 4'd6, 4'd0, 4'h0, 1'b0, 4'd0);
    tick();
    idle(4'd5, 4'd4, 4'd6, 4'd0, 4'h0);
    #1 checkOutput("dual write");
    checkValue("dual r4", rdOf(1), 32'h4444_4444);
    checkValue("dual r6", rdOf(2), 32'h6666_6666);

    $display("[TB] scoreboard set and clear");
    applyStimulus(2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 4'd0, 4'd0, 4'd7, 4'd0, 4'b0100, 1'b1, 4'd7);
    tick();
    idle(4'd0, 4'd0, 4'd7, 4'd0, 4'b0100);
    #1 checkOutput("pend r7");
    checkBit("pend r7 busy", bus.rd_busy[2], 1'b1);
    checkBit("pend r7 stall", bus.stall, 1'b1);
    applyStimulus(2'b10, 4'd0, 32'd0, 4'd7, 32'h1234_5678, 4'd0, 4'd0, 4'd7, 4'd0, 4'b0100, 1'b0, 4'd0);
    #1 checkOutput("clear r7 pre");
    tick();
    idle(4'd0, 4'd0, 4'd7, 4'd0, 4'b0100);
    #1 checkOutput("clear r7 post");
    checkBit("clear r7 busy", bus.rd_busy[2], 1'b0);
    checkBit("clear r7 stall", bus.stall, 1'b0);
    checkValue("clear r7 data", rdOf(2), 32'h1234_5678);

    applyStimulus(2'b01, 4'd9, 32'h9999_0000, 4'd0, 32'd0, 4'd9, 4'd0, 4'd0, 4'd0, 4'b0001, 1'b1, 4'd9);
    #1 checkOutput("set+write r9 pre");
    tick();
    idle(4'd9, 4'd0, 4'd0, 4'd0, 4'b0001);
    #1 checkOutput("set+write r9 post");
    checkValue("r9 data", rdOf(0), 32'h9999_0000);
    checkBit("r9 still busy", bus.rd_busy[0], 1'b1);

    $display("[TB] PC slot");
    applyStimulus(2'b01, 4'd15, 32'h0000_DEAD, 4'd0, 32'd0, 4'd15, 4'd5, 4'd4, 4'd6, 4'hF, 1'b1, 4'd15);
    #1 checkOutput("pc write pre");
    tick();
    idle(4'd15, 4'd5, 4'd4, 4'd6, 4'hF);
    #1 checkOutput("pc write post");
    checkValue("pc read", rdOf(0), 32'h0000_1008);
    checkBit("pc not busy", bus.rd_busy[0], 1'b0);
    checkValue("r5 intact", rdOf(1), 32'hAAAA_0000);

    $display("[TB] write-then-read timing");
    applyStimulus(2'b01, 4'd2, 32'h0000_CAFE, 4'd0, 32'd0, 4'd0, 4'd2, 4'd0, 4'd0, 4'h0, 1'b0, 4'd0);
    #1 checkOutput("r2 pre");
`ifdef REGFILE_BYPASS_EN
    checkValue("r2 forwarded", rdOf(1), 32'h0000_CAFE);
`else
    checkValue("r2 old value", rdOf(1), 32'h0);
`endif
    tick();
    idle(4'd0, 4'd2, 4'd0, 4'd0, 4'h0);
    #1 checkOutput("r2 post");
    checkValue("r2 stored", rdOf(1), 32'h0000_CAFE);

    $display("[TB] mid-test reset");
    applyStimulus(2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 4'd5, 4'd7, 4'd15, 4'd0, 4'hF, 1'b1, 4'd7);
    tick();
    idle(4'd5, 4'd7, 4'd15, 4'd0, 4'hF);
    #1 checkOutput("pre-reset");
    checkBit("pre-reset r7 busy", bus.rd_busy[1], 1'b1);
    applyStimulus(2'b01, 4'd5, 32'h0BAD_0BAD, 4'd0, 32'd0, 4'd5, 4'd7, 4'd15, 4'd0, 4'hF, 1'b1, 4'd3);
    #1 reset = 1'b0;
    modelClear();
    #1 checkOutput("in reset");
    checkValue("in reset r5", rdOf(0), 32'h0);
    checkBit("in reset r7 busy", bus.rd_busy[1], 1'b0);
    checkValue("in reset pc", rdOf(2), 32'h0000_1008);
    checkBit("in reset stall", bus.stall, 1'b0);
    tick();
    reset = 1'b1;
    idle(4'd5, 4'd7, 4'd3, 4'd15, 4'hF);
    #1 checkOutput("after reset");
    checkValue("after reset r5", rdOf(0), 32'h0);

    $display("[TB] random traffic");
    for (int c = 0; c < 300; c++) begin
      w0 = 4'($urandom_range(0, 15));
      applyStimulus(2'($urandom_range(0, 3)),
                    w0, $urandom,
                    ($urandom_range(0, 3) == 0) ? w0 : 4'($urandom_range(0, 15)), $urandom,
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) == 0),
                    4'($urandom_range(0, 15)));
      bus.pc_in = $urandom;
      #1 checkOutput("rand");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
